// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 Set 2 key decoder.
//   - Scancode prefix and special byte constants.
//   - Decoder FSM state enum.
//   - 10-bit key event struct {rel, ext, code} and a small constructor.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_e;

  // "release" is a reserved word, hence the short field name.
  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

  function automatic ps2_evt_t make_evt(input logic rel, input logic ext,
                                        input logic [7:0] code);
    ps2_evt_t e;
    e.rel  = rel;
    e.ext  = ext;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: DEPTH x WIDTH first-word-fall-through FIFO.
//   clk, resetn     : clock, asynchronous active-low reset
//   push_req/data   : write request; accepted when not full or when popping
//   pop_req         : consumer takes the head entry (ignored while empty)
//   head_data       : registered head entry, holds while empty or not popped
//   empty, full     : derived from (log2(DEPTH)+1)-bit wrapping pointers
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_req,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_req & ~empty;
  // A pop frees a slot in the same cycle, so full+pop+push is accepted.
  assign do_push = push_req & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    head_d   = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      // The new head is the entry being written this cycle only when the
      // FIFO is (or becomes) empty before the write lands: bypass it.
      if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_d = push_data;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  // Storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  assign head_data = head_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: strips E0/F0/E1 prefixes from Set 2 scancode bytes and
// queues one key event per make/break in a FWFT FIFO.
//   clk, resetn             : clock, asynchronous active-low reset
//   byte_valid, byte_data   : one-cycle strobe with a received scancode byte
//   evt_valid, evt_ready    : head event handshake (pop on valid & ready)
//   evt_code/ext/release    : head event fields, held while not popped
//   overflow, ovf_clr       : sticky event-dropped flag and its clear
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppresses repeated makes of a
// key that is already held, using a 512-entry {ext,code} held-key map.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PAUSE_LEN  = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_release,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int SKIP_W = (PAUSE_LEN < 2) ? 1 : $clog2(PAUSE_LEN + 1);

  ps2_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              overflow_q, overflow_d;
  logic              evt_gen;
  ps2_evt_t          evt_new;
  logic              push_req;
  logic              is_err, is_ignored;
  logic              fifo_empty, fifo_full, fifo_pop, fifo_drop;
  logic [9:0]        head_bits;
  ps2_evt_t          head_evt;

  assign is_err     = (byte_data == PS2_ERR0) || (byte_data == PS2_ERR1);
  assign is_ignored = is_err || (byte_data == PS2_BAT) || (byte_data == PS2_ACK) ||
                      (byte_data == PS2_ECHO) || (byte_data == PS2_RESEND);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    evt_gen = 1'b0;
    evt_new = make_evt(1'b0, 1'b0, byte_data);
    if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_data == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (byte_data == PS2_BRK) begin
            state_d = ST_BRK;
          end else if (byte_data == PS2_PAUSE) begin
            // Pause is reported once; its trailing bytes are swallowed.
            state_d = (PAUSE_LEN == 0) ? ST_IDLE : ST_PAUSE;
            skip_d  = SKIP_W'(PAUSE_LEN);
            evt_gen = 1'b1;
            evt_new = make_evt(1'b0, 1'b0, PS2_PAUSE);
          end else if (!is_ignored) begin
            evt_gen = 1'b1;
          end
        end
        ST_EXT: begin
          if (byte_data == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (byte_data != PS2_EXT) begin
            state_d = ST_IDLE;
            evt_gen = ~is_err;
            evt_new = make_evt(1'b0, 1'b1, byte_data);
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          evt_gen = ~is_err;
          evt_new = make_evt(1'b1, 1'b0, byte_data);
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          evt_gen = ~is_err;
          evt_new = make_evt(1'b1, 1'b1, byte_data);
        end
        ST_PAUSE: begin
          if (skip_q <= SKIP_W'(1)) begin
            state_d = ST_IDLE;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - SKIP_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          skip_d  = '0;
        end
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0] held_q, held_d;
  logic [8:0]   held_idx;
  logic         is_pause_evt;

  assign held_idx     = {evt_new.ext, evt_new.code};
  // Only the IDLE-state E1 is the Pause event; E0 E1 is an ordinary key.
  assign is_pause_evt = (state_q == ST_IDLE) && (byte_data == PS2_PAUSE);

  always_comb begin
    held_d   = held_q;
    push_req = evt_gen;
    if (evt_gen && !is_pause_evt) begin
      if (evt_new.rel) begin
        held_d[held_idx] = 1'b0;
      end else if (held_q[held_idx]) begin
        push_req = 1'b0;
      end else begin
        held_d[held_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held_q <= '0;
    end else begin
      held_q <= held_d;
    end
  end
`else
  assign push_req = evt_gen;
`endif

  assign fifo_pop  = evt_valid & evt_ready;
  assign fifo_drop = push_req & fifo_full & ~fifo_pop;

  // A drop in the same cycle as a clear leaves the flag set.
  assign overflow_d = (overflow_q & ~ovf_clr) | fifo_drop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push_req  (push_req),
    .push_data (evt_new),
    .pop_req   (fifo_pop),
    .head_data (head_bits),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign head_evt    = ps2_evt_t'(head_bits);
  assign evt_valid   = ~fifo_empty;
  assign evt_code    = head_evt.code;
  assign evt_ext     = head_evt.ext;
  assign evt_release = head_evt.rel;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// byte-level reference model with a queue as the event FIFO.
module tb_ps2_key_decoder;

  localparam int DEPTH = 8;
  localparam int PLEN  = 7;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .FIFO_DEPTH (DEPTH),
    .PAUSE_LEN  (PLEN)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_release (evt_release),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0]   mq[$];
  logic [9:0]   m_shown = '0;
  bit           m_ovf = 0;
  bit           m_ext = 0;
  bit           m_brk = 0;
  int           m_skip = 0;
  logic [511:0] m_held = '0;

  // Interprets one byte given the pending prefixes; returns the event, if any.
  function automatic void decode(input logic [7:0] b, output bit has, output logic [9:0] ev);
    bit pause_evt;
    has = 0;
    ev = '0;
    pause_evt = 0;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'h00 || b == 8'hFF) begin
      m_ext = 0;
      m_brk = 0;
    end else if (m_brk) begin
      has = 1;
      ev = {1'b1, m_ext, b};
      m_ext = 0;
      m_brk = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        has = 1;
        ev = {2'b01, b};
        m_ext = 0;
      end
    end else begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) begin
        m_skip = PLEN;
        has = 1;
        pause_evt = 1;
        ev = {2'b00, 8'hE1};
      end else if (!(b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) begin
        has = 1;
        ev = {2'b00, b};
      end
    end
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (has && !pause_evt) begin
      if (ev[9]) m_held[ev[8:0]] = 1'b0;
      else if (m_held[ev[8:0]]) has = 0;
      else m_held[ev[8:0]] = 1'b1;
    end
`endif
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_shown = '0;
      m_ovf = 0;
      m_ext = 0;
      m_brk = 0;
      m_skip = 0;
      m_held = '0;
    end else begin : upd
      bit pop, has, drop;
      logic [9:0] ev;
      pop = (mq.size() > 0) && evt_ready;
      has = 0;
      ev = '0;
      if (byte_valid) decode(byte_data, has, ev);
      if (pop) void'(mq.pop_front());
      drop = 0;
      if (has) begin
        if (mq.size() < DEPTH) mq.push_back(ev);
        else drop = 1;
      end
      m_ovf = drop | (m_ovf & !ovf_clr);
      if (mq.size() > 0) m_shown = mq[0];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("evt_valid", {31'b0, evt_valid}, {31'b0, mq.size() != 0});
    chk("evt_head", {22'b0, evt_release, evt_ext, evt_code}, {22'b0, m_shown});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  end

  // Record each accepted event (pop happens at the next rising edge).
  logic [9:0] got[$];
  always @(negedge clk) begin
    if (resetn && evt_valid && evt_ready) begin
      got.push_back({evt_release, evt_ext, evt_code});
      $display("event code=%02h ext=%0b release=%0b", evt_code, evt_ext, evt_release);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    got.delete();
  endtask

  logic [9:0] exp_q[$];

  task automatic check_got(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk(name, {22'b0, got[i]}, {22'b0, exp_q[i]});
    end
    got.delete();
    exp_q.delete();
  endtask

  logic [7:0] specials [6];

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 12) return 8'hE0;
    if (r < 24) return 8'hF0;
    if (r < 27) return 8'hE1;
    if (r < 33) return specials[$urandom_range(0, 5)];
    if (r < 60) return 8'(8'h10 + $urandom_range(0, 7));
    return 8'($urandom_range(1, 8'h7F));
  endfunction

  initial begin
    specials[0] = 8'hAA; specials[1] = 8'hFA; specials[2] = 8'hEE;
    specials[3] = 8'hFE; specials[4] = 8'h00; specials[5] = 8'hFF;

    idle(2);
    resetn = 1'b1;
    chk("rst_valid", {31'b0, evt_valid}, 32'd0);
    chk("rst_code", {24'b0, evt_code}, 32'd0);
    chk("rst_flags", {30'b0, evt_ext, evt_release}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);

    // Make then break, with one-cycle latency into an empty FIFO.
    evt_ready = 1'b1;
    send(8'h1C);
    chk("latency_valid", {31'b0, evt_valid}, 32'd1);
    chk("latency_code", {24'b0, evt_code}, 32'h1C);
    send(8'hF0); send(8'h1C);
    idle(3);
    exp_q.push_back(10'h01C); exp_q.push_back(10'h21C);
    check_got("make_break");
    chk("mb_ovf", {31'b0, overflow}, 32'd0);

    // Extended make and break.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    idle(3);
    exp_q.push_back(10'h175); exp_q.push_back(10'h375);
    check_got("extended");

    // Pause sequence collapses to one event.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    idle(3);
    exp_q.push_back(10'h0E1); exp_q.push_back(10'h01C);
    check_got("pause");

    // Fill past capacity with the consumer stalled.
    apply_reset();
    evt_ready = 1'b0;
    for (int k = 0; k < 9; k++) send(8'(8'h15 + k));
    idle(1);
    chk("full_ovf", {31'b0, overflow}, 32'd1);
    chk("full_head", {24'b0, evt_code}, 32'h15);
    evt_ready = 1'b1;
    idle(12);
    evt_ready = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back(10'(8'h15 + k));
    check_got("drain");
    chk("drained_valid", {31'b0, evt_valid}, 32'd0);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'b0, overflow}, 32'd0);

    // Ignored bytes, error inside a break, then reset mid-prefix.
    apply_reset();
    evt_ready = 1'b1;
    send(8'hAA); send(8'hFA); send(8'hF0); send(8'h00); send(8'h1C);
    idle(3);
    exp_q.push_back(10'h01C);
    check_got("ignored");
    evt_ready = 1'b0;
    send(8'h2A); send(8'hE0); send(8'hF0);
    chk("pre_rst_valid", {31'b0, evt_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, evt_valid}, 32'd0);
    tick();
    resetn = 1'b1;
    got.delete();
    evt_ready = 1'b1;
    send(8'h75);
    idle(3);
    exp_q.push_back(10'h075);
    check_got("after_reset");

`ifdef PS2_TYPEMATIC_FILTER_EN
    apply_reset();
    evt_ready = 1'b1;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    idle(3);
    exp_q.push_back(10'h01C); exp_q.push_back(10'h21C); exp_q.push_back(10'h01C);
    check_got("typematic");
`endif

    // Randomized traffic; the per-cycle compare does the checking.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      int ready_pct;
      ready_pct = ((c / 400) % 2 == 0) ? 70 : 15;
      byte_valid = ($urandom_range(0, 99) < 55);
      byte_data = pick_byte();
      evt_ready = ($urandom_range(0, 99) < ready_pct);
      ovf_clr = ($urandom_range(0, 29) == 0);
      if (c == 1500) resetn = 1'b0;
      if (c == 1502) resetn = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    ovf_clr = 1'b0;
    evt_ready = 1'b1;
    idle(DEPTH + 4);
    got.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
